player_motion: RTL and testbench

Per-player kinematics stage that sits directly downstream of the player controller (human keypad decoder or computer opponent). It consumes the controller's move-left / move-right / jump / smash command levels once per video frame. It integrates horizontal motion, a gravity-driven jump arc and a timed smash window. It produces the registered player position and status flags, which feed the collision/ball-physics stage, the renderer, and the controller's own position inputs.

---
 rtl/player_motion.sv | 174 +++++++++++++++++
 tb/tb_player_motion.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/player_motion.sv
// Per-player kinematics: frame-stepped horizontal motion, gravity jump arc and
// a timed smash window, all outputs registered.
module player_motion #(
   parameter logic [9:0] INIT_X          = 10'd60,
   parameter logic [9:0] X_MIN           = 10'd20,
   parameter logic [9:0] X_MAX           = 10'd300,
   parameter logic [9:0] GROUND_Y        = 10'd320,
   parameter int         SPEED_X         = 4,
   parameter int         JUMP_V0         = 12,
   parameter int         GRAVITY         = 1,
   parameter int         SMASH_FRAMES    = 8,
   parameter int         COOLDOWN_FRAMES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       freeze,
   input  logic       move_left,
   input  logic       move_right,
   input  logic       jump,
   input  logic       smash,
   output logic [9:0] pos_x,
   output logic [9:0] pos_y,
   output logic       airborne,
   output logic       smash_active
);

   typedef enum logic {V_GROUND, V_AIR} vstate_t;
   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_COOLDOWN} sstate_t;

   localparam logic [10:0]       LO_LIM   = {1'b0, X_MIN} + 11'(SPEED_X);
   localparam logic [10:0]       HI_LIM   = {1'b0, X_MAX} - 11'(SPEED_X);
   localparam logic signed [11:0] GRAV_S  = 12'(GRAVITY);
   localparam logic signed [11:0] V0_S    = 12'(JUMP_V0);
   localparam logic signed [11:0] GROUND_S = $signed({2'b00, GROUND_Y});

   logic              update_s;
   logic [9:0]        pos_x_r;
   logic [9:0]        next_x_s;
   logic [9:0]        pos_y_r;
   logic signed [7:0] vy_r;
   logic signed [11:0] next_y_s;
   logic signed [11:0] vy_inc_s;
   vstate_t           vstate_r;
   logic              airborne_r;
   sstate_t           sstate_r;
   logic [4:0]        cnt_r;
   logic              smash_active_r;

   assign update_s = frame_tick & ~freeze;

   // Horizontal next position with 11-bit clamp guards so nothing wraps
   always_comb begin
      next_x_s = pos_x_r;
      if (move_left && !move_right) begin
         if ({1'b0, pos_x_r} < LO_LIM) begin
            next_x_s = X_MIN;
         end else begin
            next_x_s = pos_x_r - 10'(SPEED_X);
         end
      end else if (move_right && !move_left) begin
         if ({1'b0, pos_x_r} > HI_LIM) begin
            next_x_s = X_MAX;
         end else begin
            next_x_s = pos_x_r + 10'(SPEED_X);
         end
      end else begin
         next_x_s = pos_x_r;
      end
   end

   // Signed 12-bit arc arithmetic
   always_comb begin
      next_y_s = $signed({2'b00, pos_y_r}) + $signed({{4{vy_r[7]}}, vy_r});
      vy_inc_s = $signed({{4{vy_r[7]}}, vy_r}) + GRAV_S;
   end

   // Horizontal position register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos_x_r <= INIT_X;
      end else if (update_s) begin
         pos_x_r <= next_x_s;
      end
   end

   // Vertical FSM: ground / air with gravity; landing update ignores jump
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos_y_r    <= GROUND_Y;
         vy_r       <= 8'sd0;
         vstate_r   <= V_GROUND;
         airborne_r <= 1'b0;
      end else if (update_s) begin
         case (vstate_r)
            V_GROUND: begin
               if (jump) begin
                  pos_y_r    <= GROUND_Y - 10'(JUMP_V0);
                  vy_r       <= 8'(GRAV_S - V0_S);
                  vstate_r   <= V_AIR;
                  airborne_r <= 1'b1;
               end else begin
                  pos_y_r    <= GROUND_Y;
                  vy_r       <= 8'sd0;
                  airborne_r <= 1'b0;
               end
            end
            V_AIR: begin
               if (next_y_s >= GROUND_S) begin
                  pos_y_r    <= GROUND_Y;
                  vy_r       <= 8'sd0;
                  vstate_r   <= V_GROUND;
                  airborne_r <= 1'b0;
               end else begin
                  pos_y_r <= next_y_s[9:0];
                  vy_r    <= (vy_inc_s > V0_S) ? V0_S[7:0] : vy_inc_s[7:0];
               end
            end
            default: begin
               pos_y_r    <= GROUND_Y;
               vy_r       <= 8'sd0;
               vstate_r   <= V_GROUND;
               airborne_r <= 1'b0;
            end
         endcase
      end
   end

   // Smash FSM sharing one frame counter between the window and the cooldown
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sstate_r       <= S_IDLE;
         cnt_r          <= 5'd0;
         smash_active_r <= 1'b0;
      end else if (update_s) begin
         case (sstate_r)
            S_IDLE: begin
               if (smash) begin
                  sstate_r       <= S_ACTIVE;
                  cnt_r          <= 5'(SMASH_FRAMES - 1);
                  smash_active_r <= 1'b1;
               end
            end
            S_ACTIVE: begin
               if (cnt_r == 5'd0) begin
                  sstate_r       <= S_COOLDOWN;
                  cnt_r          <= 5'(COOLDOWN_FRAMES - 1);
                  smash_active_r <= 1'b0;
               end else begin
                  cnt_r <= cnt_r - 5'd1;
               end
            end
            S_COOLDOWN: begin
               if (cnt_r == 5'd0) begin
                  sstate_r <= S_IDLE;
               end else begin
                  cnt_r <= cnt_r - 5'd1;
               end
            end
            default: begin
               sstate_r       <= S_IDLE;
               cnt_r          <= 5'd0;
               smash_active_r <= 1'b0;
            end
         endcase
      end
   end

   assign pos_x        = pos_x_r;
   assign pos_y        = pos_y_r;
   assign airborne     = airborne_r;
   assign smash_active = smash_active_r;

endmodule

// File: tb/tb_player_motion.sv
// Directed plus randomized bench for player_motion against a frame-level
// behavioural model of position, jump arc and smash timing.
module tb_player_motion;

   logic       clk = 1'b0;
   logic       rst;
   logic       frame_tick;
   logic       freeze;
   logic       move_left;
   logic       move_right;
   logic       jump;
   logic       smash;
   logic [9:0] pos_x;
   logic [9:0] pos_y;
   logic       airborne;
   logic       smash_active;

   int n_cmp = 0;
   int n_err = 0;

   // model state: x, y, vertical speed, air flag, frames since smash trigger (-1 = idle)
   int m_x, m_y, m_vy, m_phase;
   bit m_air;

   localparam int XMIN = 20, XMAX = 300, GY = 320, SPX = 4, V0 = 12, GR = 1;
   localparam int SMF = 8, CDF = 16;

   player_motion dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .freeze(freeze),
      .move_left(move_left), .move_right(move_right), .jump(jump), .smash(smash),
      .pos_x(pos_x), .pos_y(pos_y), .airborne(airborne), .smash_active(smash_active)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_x = 60; m_y = GY; m_vy = 0; m_air = 0; m_phase = -1;
   endtask

   task automatic model_step(input bit l, input bit r, input bit j, input bit s);
      int ny;
      if (l && !r) m_x = (m_x - SPX < XMIN) ? XMIN : m_x - SPX;
      else if (r && !l) m_x = (m_x + SPX > XMAX) ? XMAX : m_x + SPX;
      if (!m_air) begin
         if (j) begin
            m_y = GY - V0; m_vy = GR - V0; m_air = 1;
         end
      end else begin
         ny = m_y + m_vy;
         if (ny >= GY) begin
            m_y = GY; m_vy = 0; m_air = 0;
         end else begin
            m_y = ny; m_vy = (m_vy + GR > V0) ? V0 : m_vy + GR;
         end
      end
      if (m_phase < 0) begin
         if (s) m_phase = 0;
      end else begin
         m_phase = m_phase + 1;
         if (m_phase == SMF + CDF) m_phase = -1;
      end
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".x"}, int'(pos_x), m_x);
      check({tag, ".y"}, int'(pos_y), m_y);
      check({tag, ".air"}, int'(airborne), int'(m_air));
      check({tag, ".smash"}, int'(smash_active), (m_phase >= 0 && m_phase < SMF) ? 1 : 0);
   endtask

   task automatic step(input string tag, input bit l, input bit r, input bit j,
                       input bit s, input bit fz, input bit tick);
      @(negedge clk);
      move_left = l; move_right = r; jump = j; smash = s; freeze = fz; frame_tick = tick;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      if (tick && !fz) model_step(l, r, j, s);
      check_all(tag);
   endtask

   task automatic async_reset(input string tag);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; frame_tick = 1'b0; freeze = 1'b0;
      move_left = 1'b0; move_right = 1'b0; jump = 1'b0; smash = 1'b0;
      model_reset();
      #3;
      check_all("reset");
      @(negedge clk);
      rst = 1'b0;
      step("idle_tick", 0, 0, 0, 0, 0, 1);

      // full jump arc with jump held, then immediate re-jump
      for (int i = 1; i <= 26; i++) begin
         step("arc", 0, 0, 1, 0, 0, 1);
         if (i == 1)  check("arc_u1_y", int'(pos_y), 308);
         if (i == 12) check("arc_apex_y", int'(pos_y), 242);
         if (i == 24) check("arc_u24_air", int'(airborne), 1);
         if (i == 25) begin
            check("arc_land_y", int'(pos_y), 320);
            check("arc_land_air", int'(airborne), 0);
         end
         if (i == 26) check("arc_rejump_y", int'(pos_y), 308);
         if (i < 26) step("arc_gap", 1, 0, 0, 1, 0, 0);
      end

      // mid-arc, mid-smash asynchronous reset
      for (int i = 0; i < 4; i++) step("pre_rst", 0, 1, 1, 1, 0, 1);
      async_reset("rst_mid_arc");
      check("rst_mid_arc_y", int'(pos_y), 320);

      // left clamp, then both held
      for (int i = 0; i < 12; i++) step("left", 1, 0, 0, 0, 0, 1);
      check("left_clamp", int'(pos_x), 20);
      for (int i = 0; i < 3; i++) step("both", 1, 1, 0, 0, 0, 1);

      // right clamp while jumping
      for (int i = 0; i < 75; i++) step("right", 0, 1, 1, 0, 0, 1);
      check("right_clamp", int'(pos_x), 300);

      // smash held through window, cooldown and re-trigger
      for (int i = 1; i <= 30; i++) begin
         step("smash_hold", 0, 0, 0, 1, 0, 1);
         if (i == 8) check("smash_u8", int'(smash_active), 1);
         if (i == 9) check("smash_u9", int'(smash_active), 0);
      end
      // single pulse during cooldown is ignored
      for (int i = 0; i < 10; i++) step("smash_run", 0, 0, 0, 0, 0, 1);
      step("cd_pulse", 0, 0, 0, 1, 0, 1);
      for (int i = 0; i < 20; i++) step("cd_after", 0, 0, 0, 0, 0, 1);

      // freeze mid-jump and mid-smash, then resume
      for (int i = 0; i < 5; i++) step("pre_frz", 0, 0, 1, 1, 0, 1);
      for (int i = 0; i < 10; i++) step("frz", 1, 0, 1, 1, 1, 1);
      for (int i = 0; i < 30; i++) step("post_frz", 0, 0, 0, 0, 0, 1);

      // randomized commands, ticks and freezes
      for (int i = 0; i < 400; i++) begin
         step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
         if (i == 200) async_reset("rand_rst");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
